// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM core: run-state encoding, counter
// ceiling and dead-time counter sizing.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Largest step-counter value for a given resolution (2^res - 1).
    function automatic int unsigned cnt_max(input int unsigned res);
        return (32'd1 << res) - 32'd1;
    endfunction

    // Width needed to hold a dead-time count of dt (at least one bit).
    function automatic int unsigned dt_width(input int unsigned dt);
        return (dt < 2) ? 1 : $clog2(dt + 1);
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter for complementary PWM outputs; compiled only when
// PWM_COMPLEMENT_EN is defined.
`ifdef PWM_COMPLEMENT_EN
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEADTIME = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic en,
    output logic hi,
    output logic lo
);

    localparam int DT_W = dt_width(DEADTIME);

    logic [DT_W-1:0] dt_reg;
    logic            raw_prev_reg;

    // Every raw edge blanks both sides for DEADTIME clocks; an edge arriving
    // while blanked reloads the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dt_reg       <= '0;
            raw_prev_reg <= 1'b0;
            hi           <= 1'b0;
            lo           <= 1'b0;
        end else if (!en) begin
            dt_reg       <= '0;
            raw_prev_reg <= raw;
            hi           <= 1'b0;
            lo           <= 1'b0;
        end else if (raw != raw_prev_reg) begin
            raw_prev_reg <= raw;
            dt_reg       <= DT_W'(DEADTIME - 1);
            hi           <= 1'b0;
            lo           <= 1'b0;
        end else if (dt_reg != '0) begin
            dt_reg <= dt_reg - 1'b1;
            hi     <= 1'b0;
            lo     <= 1'b0;
        end else begin
            hi <= raw;
            lo <= !raw;
        end
    end

endmodule
`endif

// File: rtl/pwm_core.sv
// PWM core: tick-driven step counter, compare against a double-buffered duty.
// Define PWM_COMPLEMENT_EN to add a complementary output with dead time.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int RESOLUTION = 8,
    parameter int DEADTIME   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic [RESOLUTION-1:0] duty_in,
    input  logic                  duty_valid,
    output logic                  duty_ready,
    output logic                  pwm_out,
    output logic                  pwm_n,
    output logic                  period_end
);

    localparam logic [RESOLUTION-1:0] CNT_MAX = RESOLUTION'(cnt_max(RESOLUTION));

    state_t                  state_reg, state_next;
    logic [RESOLUTION-1:0]   cnt_reg;
    logic [RESOLUTION-1:0]   active_reg;
    logic [RESOLUTION-1:0]   shadow_reg;
    logic                    pending_reg;
    logic                    raw_reg;
    logic                    period_end_reg;

    logic running;
    logic wrap;
    logic transfer;

    assign running    = (state_reg != IDLE);
    assign wrap       = tick && running && (cnt_reg == CNT_MAX);
    assign transfer   = duty_valid && !pending_reg;
    assign duty_ready = !pending_reg;
    assign period_end = period_end_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // STOP finishes the current period; re-enabling resumes without restart.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = STOP;
            STOP: begin
                if (enable)    state_next = RUN;
                else if (wrap) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            active_reg     <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            raw_reg        <= 1'b0;
            period_end_reg <= 1'b0;
        end else begin
            if (!running)  cnt_reg <= '0;
            else if (tick) cnt_reg <= cnt_reg + 1'b1;

            period_end_reg <= wrap;
            raw_reg        <= running && (cnt_reg < active_reg);

            // A write accepted on the wrap cycle lands in shadow and waits a full period.
            if (wrap && pending_reg) begin
                active_reg  <= shadow_reg;
                pending_reg <= 1'b0;
            end
            if (transfer) begin
                if (!running) begin
                    active_reg <= duty_in;
                end else begin
                    shadow_reg  <= duty_in;
                    pending_reg <= 1'b1;
                end
            end
        end
    end

`ifdef PWM_COMPLEMENT_EN
    pwm_deadtime #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_reg),
        .en    (running),
        .hi    (pwm_out),
        .lo    (pwm_n)
    );
`else
    localparam int unused_deadtime = DEADTIME;
    assign pwm_out = raw_reg;
    assign pwm_n   = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: idle, duty patterns, shadow update, stop/restart, async reset.
`timescale 1ns/1ps
module tb_pwm_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] duty_in = 8'd0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm_out;
    logic       pwm_n;
    logic       period_end;

    int n_cmp = 0;
    int n_bad = 0;
    int div = 0;
    int both_high = 0;
    int pwmn_high = 0;

    pwm_core #(
        .RESOLUTION (8),
        .DEADTIME   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .enable     (enable),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .pwm_n      (pwm_n),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, sample, then schedule the next tick (every 4 clks).
    task automatic step();
        @(negedge clk);
        if (pwm_out && pwm_n) both_high++;
        if (pwm_n) pwmn_high++;
        tick = (div == 3);
        div  = (div + 1) % 4;
    endtask

    // High-side clocks expected within one period window for a given duty.
    function automatic int exp_hi(input int d);
`ifdef PWM_COMPLEMENT_EN
        if (d == 0)   return 0;
        if (d == 255) return 1024 - 8;
        return 4 * d - 4;
`else
        return 4 * d;
`endif
    endfunction

    task automatic wait_pe(input string tag, input int bound);
        int n = 0;
        while (!period_end && n < bound) begin
            step();
            n++;
        end
        check(tag, int'(period_end), 1);
    endtask

    // Measure one period starting at a period_end sample, with optional duty write and enable events.
    task automatic measure(input int write_at, input logic [7:0] wval, input int off_at, input int on_at,
                           output int hi, output int clks, output int ready_mid, output int both_low);
        hi = 0; clks = 0; ready_mid = -1; both_low = 0;
        do begin
            if (pwm_out) hi++;
            if (!pwm_out && !pwm_n) both_low++;
            if (clks == write_at) begin
                duty_in = wval;
                duty_valid = 1'b1;
            end else if (duty_valid) begin
                duty_valid = 1'b0;
                ready_mid = int'(duty_ready);
            end
            if (clks == off_at) enable = 1'b0;
            if (clks == on_at)  enable = 1'b1;
            step();
            clks++;
        end while (!period_end && clks < 2000);
        if (duty_valid) begin
            duty_valid = 1'b0;
            ready_mid = int'(duty_ready);
        end
        $display("period: high=%0d clks=%0d ready_after_write=%0d both_low=%0d", hi, clks, ready_mid, both_low);
    endtask

    initial begin
        int hi, clks, rdy, blow, n_pe, n_hi;

        repeat (3) step();
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_pwm_n", int'(pwm_n), 0);
        check("reset_period_end", int'(period_end), 0);
        check("reset_duty_ready", int'(duty_ready), 1);
        reset = 1'b0;

        n_pe = 0; n_hi = 0;
        repeat (2000) begin
            step();
            if (period_end) n_pe++;
            if (pwm_out) n_hi++;
        end
        check("idle_pwm_high_clks", n_hi, 0);
        check("idle_period_end_pulses", n_pe, 0);
        check("idle_duty_ready", int'(duty_ready), 1);

        duty_in = 8'd64; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        check("idle_write_ready", int'(duty_ready), 1);

        enable = 1'b1;
        wait_pe("first_wrap", 1100);
        measure(-1, 8'd0, -1, -1, hi, clks, rdy, blow);
        check("duty64_high", hi, exp_hi(64));
        check("duty64_period_clks", clks, 1024);
`ifdef PWM_COMPLEMENT_EN
        check("duty64_deadtime_clks", blow, 8);
`endif

        measure(100, 8'd200, -1, -1, hi, clks, rdy, blow);
        check("shadow_current_high", hi, exp_hi(64));
        check("shadow_period_clks", clks, 1024);
        check("shadow_ready_low", rdy, 0);
        check("shadow_ready_at_wrap", int'(duty_ready), 1);

        measure(10, 8'd0, -1, -1, hi, clks, rdy, blow);
        check("duty200_high", hi, exp_hi(200));
        check("duty0_write_ready_low", rdy, 0);

        measure(1023, 8'd255, -1, -1, hi, clks, rdy, blow);
        check("duty0_high", hi, 0);
        check("wrap_write_ready_low", rdy, 0);

        measure(-1, 8'd0, -1, -1, hi, clks, rdy, blow);
        check("wrap_write_deferred_high", hi, 0);

        measure(-1, 8'd0, -1, -1, hi, clks, rdy, blow);
        check("duty255_high", hi, exp_hi(255));
        check("duty255_period_clks", clks, 1024);
        check("duty255_ready", int'(duty_ready), 1);

        measure(-1, 8'd0, 41, -1, hi, clks, rdy, blow);
        check("stop_full_period_high", hi, exp_hi(255));
        check("stop_period_clks", clks, 1024);
        n_pe = 0; n_hi = 0;
        repeat (1100) begin
            step();
            if (period_end) n_pe++;
            if (pwm_out) n_hi++;
        end
        check("after_stop_pwm_high_clks", n_hi, 0);
        check("after_stop_period_end_pulses", n_pe, 0);

        enable = 1'b1;
        wait_pe("restart_wrap", 1100);
        measure(-1, 8'd0, 41, 200, hi, clks, rdy, blow);
        check("reenable_period_clks", clks, 1024);
        check("reenable_period_high", hi, exp_hi(255));
        measure(-1, 8'd0, -1, -1, hi, clks, rdy, blow);
        check("reenable_next_clks", clks, 1024);
        check("reenable_next_high", hi, exp_hi(255));

        repeat (20) step();
        duty_in = 8'd7; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        check("pre_reset_pending", int'(duty_ready), 0);
        check("pre_reset_high", int'(pwm_out), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_pwm_out", int'(pwm_out), 0);
        check("async_reset_pwm_n", int'(pwm_n), 0);
        check("async_reset_duty_ready", int'(duty_ready), 1);
        step();
        reset = 1'b0;
        wait_pe("post_reset_wrap", 1100);
        measure(-1, 8'd0, -1, -1, hi, clks, rdy, blow);
        check("post_reset_duty_cleared", hi, 0);

`ifdef PWM_COMPLEMENT_EN
        check("never_both_high", both_high, 0);
`else
        check("pwm_n_tied_low", pwmn_high, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_core.md
Name: pwm_core

Overview:
- Consumes the single-cycle step tick from the PWM flag generator and produces the PWM waveform.
- Runs a RESOLUTION-bit step counter advanced only on tick, and compares it against an active duty value.
- New duty values arrive through a valid/ready handshake and are applied glitch-free at period boundaries.
- Sits between the flag generator (upstream) and the pin/gate-driver logic (downstream).

Parameters:
RESOLUTION, 8, width of step counter and duty; period = 2^RESOLUTION ticks
DEADTIME, 4, dead-time length in clk cycles (used only with PWM_COMPLEMENT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-clk step strobe from flag generator
enable  in  1  run request, level
duty_in  in  RESOLUTION  requested duty, in steps
duty_valid  in  1  duty_in valid
duty_ready  out  1  core can accept duty_in
pwm_out  out  1  PWM output (high side)
pwm_n  out  1  complementary output (PWM_COMPLEMENT_EN only; else constant 0)
period_end  out  1  one-clk pulse on counter wrap

Behaviour:
- Reset (async): state=IDLE, cnt=0, active=0, shadow=0, pending=0, pwm_out=0, pwm_n=0, period_end=0, duty_ready=1.
- States:
  - IDLE: cnt held 0, pwm_out=0. enable=1 -> RUN next clk.
  - RUN: on clk with tick=1, cnt<=cnt+1 modulo 2^RESOLUTION. enable=0 -> STOP.
  - STOP: keeps counting until wrap; on wrap -> IDLE. enable=1 while in STOP -> RUN, no restart.
  - No truncated periods are ever emitted.
- Wrap: tick=1 with cnt=2^RESOLUTION-1 in RUN/STOP.
  - cnt<=0 and period_end=1 for exactly that following clk.
  - If pending=1: active<=shadow, pending<=0.
- Handshake: duty_ready = !pending. Transfer occurs when duty_valid && duty_ready.
  - IDLE: transfer writes active directly; pending stays 0.
  - RUN/STOP: transfer writes shadow and sets pending=1. A value captured on the wrap cycle itself applies at the next wrap, not the current one.
- pwm_out is registered: pwm_out <= (state!=IDLE) && (cnt < active). It lags cnt by 1 clk.
  - duty=0: constant low.
  - duty=2^RESOLUTION-1: high for 255/256 steps at default width; 100% is not reachable by design.
- tick while in IDLE is ignored. tick and enable fall on the same clk: the tick is counted, then the state goes to STOP.
- Reset mid-period: immediate return to reset values; any pending duty is discarded.

Optional Feature:
- Macro PWM_COMPLEMENT_EN.
- Defined: the raw compare output feeds a dead-time inserter.
  - Any raw edge forces both outputs low for DEADTIME clks, then asserts pwm_out (raw=1) or pwm_n (raw=0).
  - A raw edge during dead time restarts the dead-time count.
  - In IDLE, both outputs are 0 with no dead-time sequence.
- Undefined: pwm_out = raw registered compare, pwm_n tied 0, no inserter logic.

Decomposition:
- Package pwm_pkg:
  - state enum (IDLE, RUN, STOP)
  - function giving the counter max value for a resolution
  - dead-time counter width derived from DEADTIME
- Sub-module pwm_deadtime (clk, reset, raw, en, hi, lo), instantiated only under PWM_COMPLEMENT_EN.

Test Plan:
- Reset/idle: tick every 4 clks, enable=0 -> pwm_out=0, cnt=0, period_end never pulses, duty_ready=1.
- Basic run: IDLE write duty=64, enable=1, RESOLUTION=8, tick every 4 clks -> pwm_out high 64 ticks (256 clks), low 192 ticks; period_end every 1024 clks.
- Shadow update: mid-period write 200 -> duty_ready drops, current period stays at 64, next period at 200, duty_ready rises at wrap.
- Boundaries: duty=0 -> never high; duty=255 -> low exactly 1 tick per period. Write issued on the wrap clk -> applied one period later.
- Graceful stop: drop enable at cnt=10 -> waveform finishes through cnt=255, period_end pulses once, then IDLE with pwm_out=0. Re-enabling in STOP -> no gap in counting.
- PWM_COMPLEMENT_EN, DEADTIME=4, duty=64 -> pwm_out/pwm_n never both high, both low exactly 4 clks at each edge; async reset mid-high drives both to 0 immediately.
